// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode values, FSM state
// encoding, next-PC selector codes and the opcode field width.
package instr_sequencer_pkg;

    // Opcode field is the top OP_W bits of the instruction word
    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_CLA  = 4'd0;
    localparam logic [OP_W-1:0] OP_COM  = 4'd1;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd2;
    localparam logic [OP_W-1:0] OP_CSL  = 4'd3;
    localparam logic [OP_W-1:0] OP_STOP = 4'd4;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd5;
    localparam logic [OP_W-1:0] OP_STA  = 4'd6;
    localparam logic [OP_W-1:0] OP_LDA  = 4'd7;
    localparam logic [OP_W-1:0] OP_JMP  = 4'd8;
    localparam logic [OP_W-1:0] OP_BAN  = 4'd9;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_LOAD  = 3'd2;
    localparam state_t S_EXEC  = 3'd3;
    localparam state_t S_HALT  = 3'd4;

    // Next-PC source selection
    typedef logic [1:0] pc_sel_t;
    localparam pc_sel_t PC_HOLD  = 2'd0;
    localparam pc_sel_t PC_INC   = 2'd1;
    localparam pc_sel_t PC_JUMP  = 2'd2;
    localparam pc_sel_t PC_RESET = 2'd3;

    // Opcodes 0xA..0xF carry no meaning and execute as NOPs
    function automatic logic op_is_defined(input logic [OP_W-1:0] op);
        logic defined;
        case (op)
            OP_CLA, OP_COM, OP_SHR, OP_CSL, OP_STOP,
            OP_ADD, OP_STA, OP_LDA, OP_JMP, OP_BAN: defined = 1'b1;
            default:                                defined = 1'b0;
        endcase
        return defined;
    endfunction

endpackage

// File: rtl/instr_sequencer_pc_unit.sv
// Next-PC multiplexer: hold, increment (modulo 2^ADDR_W), jump target or
// restart address.
module instr_sequencer_pc_unit
    import instr_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] target,
    input  pc_sel_t           sel,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] pc_inc;

    // Natural truncation gives the wrap from all-ones back to zero
    assign pc_inc = pc + ADDR_W'(1);

    // Select the source of the next program counter value
    always_comb begin
        pc_next = pc;
        case (sel)
            PC_INC:   pc_next = pc_inc;
            PC_JUMP:  pc_next = target;
            PC_RESET: pc_next = RESET_PC;
            default:  pc_next = pc;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-issue sequencer: fetches a word from a synchronous ROM, holds it
// in the instruction register, resolves control flags in EXEC and raises a
// one-cycle execute strobe for the datapath.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 4 + ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         operate,
    output logic [ADDR_W-1:0]  operand_addr,
    input  logic               stop,
    input  logic               jmp,
    input  logic               ban,
    input  logic               acc_neg,
    output logic               exec_en,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc,
    output logic [15:0]        retired
);

    state_t             state_reg;
    state_t             state_next;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  pc_next;
    logic [INSTR_W-1:0] ir_reg;
    logic [15:0]        retired_reg;
    pc_sel_t            pc_sel;
    logic               ir_load;
    logic               exec_fire;

    // Decoded instruction fields come straight from the instruction register,
    // so they stay constant through EXEC
    assign operate      = ir_reg[INSTR_W-1 -: OP_W];
    assign operand_addr = ir_reg[ADDR_W-1:0];

    // Outputs decoded from state; an asynchronous reset forces IDLE and
    // therefore kills exec_en in the same instant
    assign imem_rd   = (state_reg == S_FETCH);
    assign imem_addr = pc_reg;
    assign halted    = (state_reg == S_HALT);
    assign exec_en   = exec_fire;
    assign pc        = pc_reg;
    assign retired   = retired_reg;

    // Next-state, PC source and execute decision
    always_comb begin
        state_next = state_reg;
        pc_sel     = PC_HOLD;
        ir_load    = 1'b0;
        exec_fire  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    pc_sel     = PC_RESET;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_LOAD;
            end
            S_LOAD: begin
                ir_load    = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (stop) begin
                    // PC keeps pointing at the STOP word
                    state_next = S_HALT;
                end else begin
                    state_next = S_FETCH;
                    if (jmp) begin
                        exec_fire = 1'b1;
                        pc_sel    = PC_JUMP;
                    end else if (ban) begin
                        exec_fire = 1'b1;
                        pc_sel    = acc_neg ? PC_JUMP : PC_INC;
                    end else if (!op_is_defined(operate)) begin
                        pc_sel    = PC_INC;
                    end else begin
                        exec_fire = 1'b1;
                        pc_sel    = PC_INC;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_sel     = PC_RESET;
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    instr_sequencer_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .pc      (pc_reg),
        .target  (operand_addr),
        .sel     (pc_sel),
        .pc_next (pc_next)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Program counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    // Instruction register captures ROM data during LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg <= '0;
        end else if (ir_load) begin
            ir_reg <= imem_rdata;
        end
    end

    // Saturating count of instructions that strobed exec_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_reg <= '0;
        end else if (exec_fire && (retired_reg != 16'hFFFF)) begin
            retired_reg <= retired_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a synchronous ROM and control-unit
// decode surround the DUT; an instruction-level model predicts fetch address,
// execute strobe, PC, retired count and halt status.
module tb_instr_sequencer;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               imem_rd;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic [3:0]         operate;
    logic [ADDR_W-1:0]  operand_addr;
    logic               stop;
    logic               jmp;
    logic               ban;
    logic               acc_neg = 1'b0;
    logic               exec_en;
    logic               halted;
    logic [ADDR_W-1:0]  pc;
    logic [15:0]        retired;

    logic [INSTR_W-1:0] rom [256];

    int n_checks = 0;
    int n_errors = 0;

    // Instruction-level reference state
    logic [7:0] m_pc   = 8'h00;
    int         m_ret  = 0;
    bit         m_halt = 1'b0;
    int         neg_force = -1;

    always #5 clk = ~clk;

    instr_sequencer #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (8'h00)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .imem_rd      (imem_rd),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .operate      (operate),
        .operand_addr (operand_addr),
        .stop         (stop),
        .jmp          (jmp),
        .ban          (ban),
        .acc_neg      (acc_neg),
        .exec_en      (exec_en),
        .halted       (halted),
        .pc           (pc),
        .retired      (retired)
    );

    // Synchronous instruction ROM
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= rom[imem_addr];
    end

    // Control-unit flag decode
    assign stop = (operate == 4'h4);
    assign jmp  = (operate == 4'h8);
    assign ban  = (operate == 4'h9);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_stop();
        for (int i = 0; i < 256; i++) rom[i] = 12'h400;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 8'h00; m_ret = 0; m_halt = 1'b0;
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_imem_rd", 32'(imem_rd), 32'h0);
        chk("rst_exec_en", 32'(exec_en), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_operate", 32'(operate), 32'h0);
    endtask

    // Called at the negedge of a FETCH cycle; returns at the negedge after EXEC
    task automatic run_instr();
        logic [11:0] w;
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  npc;
        logic        neg;
        logic        exp_exec;
        bit          h;
        w  = rom[m_pc];
        op = w[11:8];
        a  = w[7:0];
        neg = (neg_force < 0) ? 1'($urandom_range(0, 1)) : neg_force[0];
        acc_neg = neg;
        start = 1'($urandom_range(0, 1));   // must be ignored mid-instruction
        chk("fetch_rd", 32'(imem_rd), 32'h1);
        chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
        chk("fetch_exec", 32'(exec_en), 32'h0);
        @(negedge clk);
        chk("load_rd", 32'(imem_rd), 32'h0);
        chk("load_exec", 32'(exec_en), 32'h0);
        chk("load_halted", 32'(halted), 32'h0);
        @(negedge clk);
        h = 1'b0; exp_exec = 1'b1; npc = m_pc + 8'd1;
        if (op == 4'h4) begin
            h = 1'b1; exp_exec = 1'b0; npc = m_pc;
        end else if (op == 4'h8) begin
            npc = a;
        end else if (op == 4'h9) begin
            if (neg) npc = a;
        end else if (op >= 4'hA) begin
            exp_exec = 1'b0;
        end
        chk("exec_operate", 32'(operate), 32'(op));
        chk("exec_operand", 32'(operand_addr), 32'(a));
        chk("exec_en", 32'(exec_en), 32'(exp_exec));
        if (exp_exec && m_ret < 65535) m_ret++;
        @(negedge clk);
        start = 1'b0;
        $display("instr pc=%02h word=%03h neg=%0d exec=%0d next_pc=%02h retired=%0d halt=%0d",
                 m_pc, w, neg, exp_exec, npc, m_ret, h);
        m_pc = npc;
        m_halt = h;
        chk("post_pc", 32'(pc), 32'(m_pc));
        chk("post_retired", 32'(retired), 32'(m_ret));
        chk("post_halted", 32'(halted), 32'(h));
    endtask

    // Start from IDLE or HALT and run until STOP or the instruction budget
    task automatic run_prog(input int max_instr);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_pc = 8'h00;
        m_halt = 1'b0;
        for (int i = 0; i < max_instr && !m_halt; i++) run_instr();
        if (m_halt) begin
            repeat (2) @(negedge clk);
            chk("halt_hold", 32'(halted), 32'h1);
            chk("halt_pc", 32'(pc), 32'(m_pc));
            chk("halt_rd", 32'(imem_rd), 32'h0);
            chk("halt_retired", 32'(retired), 32'(m_ret));
        end else begin
            do_reset();
        end
    endtask

    initial begin
        fill_stop();
        repeat (2) @(negedge clk);
        chk("por_exec_en", 32'(exec_en), 32'h0);
        chk("por_imem_rd", 32'(imem_rd), 32'h0);
        do_reset();

        // ADD then STOP
        fill_stop();
        rom[0] = 12'h510;
        run_prog(10);
        chk("add_stop_pc", 32'(pc), 32'h1);
        chk("add_stop_retired", 32'(retired), 32'h1);

        // Restart from HALT keeps retired
        run_prog(10);
        chk("resume_retired", 32'(retired), 32'h2);

        // JMP 0x20 onto a STOP
        fill_stop();
        rom[0] = 12'h820;
        run_prog(10);
        chk("jmp_pc", 32'(pc), 32'h20);

        // BAN taken and not taken
        fill_stop();
        rom[0] = 12'h940;
        neg_force = 1;
        run_prog(10);
        chk("ban_neg_pc", 32'(pc), 32'h40);
        neg_force = 0;
        run_prog(10);
        chk("ban_pos_pc", 32'(pc), 32'h1);
        neg_force = -1;

        // Undefined opcode at 0xFF wraps PC to 0
        fill_stop();
        rom[0]    = 12'h8FF;
        rom[8'hFF] = 12'hB12;
        run_prog(3);

        // Reset during EXEC of STA
        fill_stop();
        rom[0] = 12'h633;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sta_exec_en", 32'(exec_en), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_exec_en", 32'(exec_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 8'h00; m_ret = 0; m_halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("after_rst_pc", 32'(pc), 32'h0);
        chk("after_rst_retired", 32'(retired), 32'h0);
        chk("after_rst_idle", 32'(imem_rd), 32'h0);
        chk("after_rst_halted", 32'(halted), 32'h0);

        // Random programs
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, 15)), 8'($urandom)};
            run_prog(40);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
